// File: rtl/fpu_arb_pkg.sv
// Shared types and requester indices for the FPU postprocess arbiters.
// Requester IDs double as the round-robin pointer encoding.
package fpu_arb_pkg;

  typedef logic [1:0] fpreq_id_t;

  localparam int NREQ = 3;

  localparam fpreq_id_t REQ_FMA     = 2'd0;
  localparam fpreq_id_t REQ_CVT     = 2'd1;
  localparam fpreq_id_t REQ_DIVSQRT = 2'd2;

  // Successor in the 0,1,2 rotation; the pointer never holds 3.
  function automatic fpreq_id_t next_id(input fpreq_id_t id);
    return (id == REQ_DIVSQRT) ? REQ_FMA : fpreq_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: combinational grant scan starting at the
// priority pointer, and the pointer register that advances past each winner.
module rr_arb3
  import fpu_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant,
  output fpreq_id_t       grant_id
);

  fpreq_id_t ptr;
  fpreq_id_t cand;

  // Scan ptr, ptr+1, ptr+2 and take the first valid requester.
  always_comb begin
    grant    = '0;
    grant_id = ptr;
    cand     = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (enable && (grant == '0) && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
      cand = next_id(cand);
    end
  end

  // A grant is always a transfer, since it is only raised for a valid requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ_FMA;
    end else if (|grant) begin
      ptr <= next_id(grant_id);
    end
  end

endmodule

// File: rtl/normshift_arb.sv
// Shared normalization left-shifter for the FMA, CVT and DIVSQRT postprocess
// paths: round-robin arbitration, one shift, one registered output stage.
module normshift_arb
  import fpu_arb_pkg::fpreq_id_t;
#(
  parameter int NORMSHIFTSZ    = 64,
  parameter int LOGNORMSHIFTSZ = 6,
  parameter int NREQ           = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Flush,
  input  logic [NREQ-1:0]                ReqValid,
  output logic [NREQ-1:0]                ReqReady,
  input  logic [NREQ*LOGNORMSHIFTSZ-1:0] ReqShiftAmt,
  input  logic [NREQ*NORMSHIFTSZ-1:0]    ReqShiftIn,
  output logic                           ResValid,
  input  logic                           ResReady,
  output logic [NORMSHIFTSZ-1:0]         ResShifted,
  output fpreq_id_t                      ResId
);

  if ((LOGNORMSHIFTSZ != $clog2(NORMSHIFTSZ)) || (NREQ != 3)) begin : g_param_check
    $error("normshift_arb: LOGNORMSHIFTSZ must be clog2(NORMSHIFTSZ) and NREQ must be 3");
  end

  logic                      can_accept;
  logic [NREQ-1:0]           grant;
  fpreq_id_t                 grant_id;
  logic [NORMSHIFTSZ-1:0]    sel_in;
  logic [LOGNORMSHIFTSZ-1:0] sel_amt;
  logic [NORMSHIFTSZ-1:0]    shifted;

  assign can_accept = ~ResValid | ResReady;

  // Gating with reset keeps ReqReady low for the whole reset pulse.
  rr_arb3 u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (can_accept & ~Flush & ~reset),
    .req_valid (ReqValid),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign ReqReady = grant;

  always_comb begin
    sel_in  = '0;
    sel_amt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_in  = ReqShiftIn[i*NORMSHIFTSZ +: NORMSHIFTSZ];
        sel_amt = ReqShiftAmt[i*LOGNORMSHIFTSZ +: LOGNORMSHIFTSZ];
      end
    end
  end

  // A shift by NORMSHIFTSZ or more already zero-fills the whole word.
  assign shifted = sel_in << sel_amt;

  // Flush wins over everything; a new transfer replaces a draining result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ResValid   <= 1'b0;
      ResShifted <= '0;
      ResId      <= '0;
    end else if (Flush) begin
      ResValid <= 1'b0;
    end else if (|grant) begin
      ResValid   <= 1'b1;
      ResShifted <= shifted;
      ResId      <= grant_id;
    end else if (ResReady) begin
      ResValid <= 1'b0;
    end
  end

endmodule
